// File: rtl/dmg_line_buf.sv
// Double-buffered scanline store between a pixel stream and the LCD controller.
// One bank is filled while the other is read out; the two trade places when the fill completes and the read bank has drained.
module dmg_line_buf #(
    parameter int HPIX = 160,
    parameter int VPIX = 144
) (
    input  logic       clk_8m,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic [1:0] wr_data,
    input  logic       wr_sof,
    output logic       wr_ready,
    input  logic [8:0] rd_x,
    input  logic [7:0] rd_y,
    input  logic       newframe,
    output logic [1:0] rd_data,
    output logic       underrun,
    output logic       resync
);
    localparam int XW = (HPIX > 1) ? $clog2(HPIX) : 1;
    localparam int YW = (VPIX > 1) ? $clog2(VPIX) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(HPIX - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VPIX - 1);

    typedef enum logic [1:0] {SYNC, FILL, HOLD} wstate_t;

    wstate_t       state, state_n;
    logic          wb, rb;
    logic [1:0]    full;
    logic [XW-1:0] wr_x, wr_x_n, waddr;
    logic [YW-1:0] wr_y, wr_y_n;
    logic          ready_en;
    logic          we, set_full, resync_n, acc;
    logic          le_q, x0_q;
    logic          x_end, x_zero, y_vis, line_end, swap;
    logic [1:0]    rd_pix;

    logic [1:0] bank0 [HPIX];
    logic [1:0] bank1 [HPIX];

    assign rb       = ~wb;
    assign wr_ready = ready_en && (state != HOLD);
    assign acc      = wr_valid && wr_ready;

    assign x_end    = (rd_x == 9'(HPIX));
    assign x_zero   = (rd_x == 9'd0);
    assign y_vis    = (rd_y < 8'(VPIX));
    assign line_end = x_end && !le_q && y_vis;
    // A swap never shares a cycle with a line-end clear, so the clear lands first.
    assign swap     = full[wb] && !full[rb] && !line_end && !newframe;

    always_comb begin
        state_n  = state;
        wr_x_n   = wr_x;
        wr_y_n   = wr_y;
        we       = 1'b0;
        waddr    = wr_x;
        set_full = 1'b0;
        resync_n = 1'b0;
        if (newframe) begin
            state_n = SYNC;
            wr_x_n  = '0;
            wr_y_n  = '0;
            if (acc && wr_sof) begin
                we      = 1'b1;
                waddr   = '0;
                wr_x_n  = XW'(1);
                state_n = FILL;
            end
        end else begin
            case (state)
                SYNC: begin
                    if (acc && wr_sof) begin
                        we      = 1'b1;
                        waddr   = '0;
                        wr_x_n  = XW'(1);
                        wr_y_n  = '0;
                        state_n = FILL;
                    end
                end
                FILL: begin
                    if (acc) begin
                        we = 1'b1;
                        if (wr_sof && wr_x != '0) begin
                            waddr    = '0;
                            wr_x_n   = XW'(1);
                            wr_y_n   = '0;
                            resync_n = 1'b1;
                        end else if (wr_x == X_LAST) begin
                            set_full = 1'b1;
                            wr_x_n   = '0;
                            if (wr_y == Y_LAST) begin
                                wr_y_n  = '0;
                                state_n = SYNC;
                            end else begin
                                wr_y_n  = wr_y + 1'b1;
                                state_n = HOLD;
                            end
                        end else begin
                            wr_x_n = wr_x + 1'b1;
                        end
                    end
                end
                HOLD: if (swap) state_n = FILL;
                default: state_n = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk_8m) begin
        if (!rst_n) begin
            state    <= SYNC;
            wb       <= 1'b0;
            full     <= 2'b00;
            wr_x     <= '0;
            wr_y     <= '0;
            ready_en <= 1'b0;
            resync   <= 1'b0;
            le_q     <= 1'b0;
            x0_q     <= 1'b0;
        end else begin
            state    <= state_n;
            wr_x     <= wr_x_n;
            wr_y     <= wr_y_n;
            ready_en <= 1'b1;
            resync   <= resync_n;
            le_q     <= x_end;
            x0_q     <= x_zero;
            if (newframe) begin
                full <= 2'b00;
            end else begin
                if (line_end) full[rb] <= 1'b0;
                if (set_full) full[wb] <= 1'b1;
                if (swap)     wb       <= ~wb;
            end
        end
    end

    // Bank storage is never cleared; the full flags decide what is visible.
    always_ff @(posedge clk_8m) begin
        if (we) begin
            if (wb) bank1[waddr] <= wr_data;
            else    bank0[waddr] <= wr_data;
        end
    end

    assign rd_pix = rb ? bank1[rd_x[XW-1:0]] : bank0[rd_x[XW-1:0]];

    always_ff @(posedge clk_8m) begin
        if (!rst_n) begin
            rd_data  <= 2'b00;
            underrun <= 1'b0;
        end else begin
            rd_data  <= (rd_x < 9'(HPIX) && y_vis && full[rb]) ? rd_pix : 2'b00;
            underrun <= x_zero && !x0_q && y_vis && !full[rb];
        end
    end
endmodule

// File: tb/tb_dmg_line_buf.sv
// Directed bench for dmg_line_buf: fill, swap, hold-off, underrun, resync, newframe and reset.
module tb_dmg_line_buf;
    logic       clk_8m = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic [1:0] wr_data;
    logic       wr_sof;
    logic       wr_ready;
    logic [8:0] rd_x;
    logic [7:0] rd_y;
    logic       newframe;
    logic [1:0] rd_data;
    logic       underrun;
    logic       resync;

    int n_tests = 0;
    int n_fail  = 0;

    dmg_line_buf dut (
        .clk_8m  (clk_8m),
        .rst_n   (rst_n),
        .wr_valid(wr_valid),
        .wr_data (wr_data),
        .wr_sof  (wr_sof),
        .wr_ready(wr_ready),
        .rd_x    (rd_x),
        .rd_y    (rd_y),
        .newframe(newframe),
        .rd_data (rd_data),
        .underrun(underrun),
        .resync  (resync)
    );

    always #5 clk_8m = ~clk_8m;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_8m);
        #1;
    endtask

    task automatic beat(input logic sof, input logic [1:0] d);
        wr_valid = 1'b1;
        wr_sof   = sof;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
        wr_sof   = 1'b0;
    endtask

    task automatic rd(input int x, input int y);
        rd_x = 9'(x);
        rd_y = 8'(y);
        tick();
    endtask

    initial begin
        int ucnt;
        logic [7:0] v;
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = 2'b00; wr_sof = 1'b0;
        rd_x = 9'd200; rd_y = 8'd0; newframe = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_resync", resync, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_wr_ready", wr_ready, 1);

        // empty read bank sweep: a single underrun, all zeros
        ucnt = 0;
        for (int x = 0; x <= 160; x++) begin
            rd(x, 0);
            chk("sweep_rd_data", rd_data, 0);
            ucnt += int'(underrun);
        end
        chk("sweep_underrun_cnt", ucnt, 1);
        rd_x = 9'd200;

        // line 0: sof + 159 beats, data = x[1:0]
        for (int i = 0; i < 160; i++) begin
            v = 8'(i);
            beat(i == 0, v[1:0]);
        end
        chk("l0_hold_ready", wr_ready, 0);
        tick();
        chk("l0_swap_fill_ready", wr_ready, 1);
        rd(5, 0);   chk("l0_x5", rd_data, 1);
        rd(6, 0);   chk("l0_x6", rd_data, 2);
        rd(159, 0); chk("l0_x159", rd_data, 3);
        rd(5, 144); chk("l0_y_oob", rd_data, 0);

        // line 1 (data = x ^ 3) fills the other bank, then hold-off until line end
        for (int i = 0; i < 160; i++) begin
            v = 8'(i);
            beat(1'b0, v[1:0] ^ 2'b11);
        end
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd(5, 0);
            chk("l1_hold_ready", wr_ready, 0);
            chk("l1_hold_read_l0", rd_data, 1);
        end
        rd(160, 0);
        chk("le_ready_t1", wr_ready, 0);
        chk("le_rd_data_oob", rd_data, 0);
        tick();
        chk("le_ready_t2", wr_ready, 1);
        wr_valid = 1'b0;
        rd(5, 1);   chk("l1_x5", rd_data, 2);
        rd(0, 1);   chk("l1_x0", rd_data, 3);
        chk("l1_no_underrun", underrun, 0);

        // resync: 77 stale beats, then sof restarts the line
        for (int i = 0; i < 77; i++) beat(1'b0, 2'b11);
        beat(1'b1, 2'd2);
        chk("resync_pulse", resync, 1);
        for (int i = 1; i < 160; i++) begin
            v = 8'(i + 2);
            beat(1'b0, v[1:0]);
            if (i == 1) chk("resync_one_cycle", resync, 0);
        end
        rd(160, 1);
        tick();
        rd(3, 2);   chk("rs_x3", rd_data, 1);
        rd(76, 2);  chk("rs_x76", rd_data, 2);
        rd(0, 2);   chk("rs_x0", rd_data, 2);
        chk("rs_no_underrun", underrun, 0);

        // newframe while holding with both banks full
        for (int i = 0; i < 160; i++) beat(1'b0, 2'd1);
        chk("nf_hold_ready", wr_ready, 0);
        rd_x = 9'd5; rd_y = 8'd0; newframe = 1'b1;
        tick();
        newframe = 1'b0;
        chk("nf_prev_read", rd_data, 3);
        chk("nf_sync_ready", wr_ready, 1);
        rd(5, 0);   chk("nf_rd_zero", rd_data, 0);

        // reset mid-fill
        rd_x = 9'd200;
        beat(1'b1, 2'd3);
        for (int i = 0; i < 20; i++) beat(1'b0, 2'd3);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_ready", wr_ready, 0);
        chk("mid_rst_underrun", underrun, 0);
        chk("mid_rst_resync", resync, 0);
        rst_n = 1'b1;
        tick();
        chk("mid_rel_ready", wr_ready, 1);
        rd(5, 0);   chk("mid_rel_rd_zero", rd_data, 0);
        rd(0, 0);   chk("mid_rel_underrun", underrun, 1);
        rd(0, 0);   chk("mid_rel_underrun_once", underrun, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmg_line_buf.md
DMG_LINE_BUF -- requirements
Module: dmg_line_buf

Interface
REQ-001 The block SHALL have parameter HPIX, default 160, giving the number of pixels per line.
REQ-002 The block SHALL have parameter VPIX, default 144, giving the number of visible lines per frame.
REQ-003 The block SHALL have port clk_8m, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port wr_valid, input, 1 bit: the upstream pixel beat is valid.
REQ-006 The block SHALL have port wr_data, input, 2 bits: the upstream pixel value.
REQ-007 The block SHALL have port wr_sof, input, 1 bit: the beat is pixel (0,0) of a frame.
REQ-008 The block SHALL have port wr_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-009 The block SHALL have port rd_x, input, 9 bits: the LCD-controller pixel x, which is out of range when it is HPIX or greater.
REQ-010 The block SHALL have port rd_y, input, 8 bits: the LCD-controller pixel y, which is out of range when it is VPIX or greater.
REQ-011 The block SHALL have port newframe, input, 1 bit: a one-cycle frame-start pulse from the LCD controller.
REQ-012 The block SHALL have port rd_data, output, 2 bits: the pixel for (rd_x, rd_y), registered.
REQ-013 The block SHALL have port underrun, output, 1 bit: a one-cycle pulse raised when a visible line had no data.
REQ-014 The block SHALL have port resync, output, 1 bit: a one-cycle pulse raised when a partial line was dropped.

Function
REQ-015 The block SHALL hold two line banks of HPIX x 2 bits each; the bank selected by register wb is the write bank and the other bank is the read bank.
REQ-016 Each bank SHALL carry a full flag; wr_x (0..HPIX-1) and wr_y (0..VPIX-1) SHALL be the write counters.
REQ-017 The write FSM SHALL have three states: SYNC, FILL and HOLD.
REQ-018 In SYNC: wr_ready=1; beats with wr_sof=0 SHALL be discarded; a beat with wr_sof=1 SHALL be stored at wr_x=0 with wr_y=0, and the FSM SHALL go to FILL.
REQ-019 In FILL: wr_ready=1; each accepted beat SHALL be written to the write bank at wr_x, and wr_x SHALL be incremented.
REQ-020 In FILL, the beat accepted at wr_x=HPIX-1 SHALL set the write bank's full flag and clear wr_x to 0.
REQ-021 On that last beat, if wr_y=VPIX-1 the FSM SHALL go to SYNC; otherwise wr_y SHALL increment and the FSM SHALL go to HOLD.
REQ-022 In HOLD: wr_ready=0; the FSM SHALL go to FILL in the cycle after a swap.
REQ-023 A beat with wr_sof=1 accepted in FILL when wr_x is not 0 SHALL set wr_x=0 and wr_y=0, store the beat at index 0, and pulse resync for one cycle.
REQ-024 Swap: in any cycle where the write bank is full and the read bank is empty, wb SHALL toggle, so the full bank becomes the read bank.
REQ-025 The swap condition SHALL be evaluated on the registered flags, so its effect is visible in the next cycle.
REQ-026 Line end SHALL be the first cycle in which rd_x=HPIX and rd_y<VPIX; the rd_x=HPIX condition is edge-detected, so each line end is counted once.
REQ-027 Line end SHALL clear the read bank's full flag.
REQ-028 When line end and the swap condition occur in the same cycle, the flag clear SHALL take effect first and the swap SHALL occur in the following cycle.
REQ-029 rd_data SHALL equal bank[read][rd_x] one clk_8m cycle after rd_x/rd_y are presented, if rd_x<HPIX, rd_y<VPIX and the read bank is full; otherwise rd_data SHALL be 2'b00.
REQ-030 underrun SHALL pulse for one cycle on the first cycle of rd_x=0 with rd_y<VPIX while the read bank is empty.
REQ-031 After an underrun, the line SHALL be read as zeros and no swap SHALL be forced.
REQ-032 newframe SHALL have highest priority: it clears both full flags, wr_x and wr_y, and sends the FSM to SYNC; wb is unchanged.
REQ-033 An accepted beat coincident with newframe SHALL be discarded, unless wr_sof=1, in which case it is stored per REQ-018.
REQ-034 All index arithmetic SHALL be unsigned; wr_x and wr_y SHALL never exceed HPIX-1 and VPIX-1 respectively.
REQ-035 The bank contents SHALL NOT be reset; the full flags alone gate rd_data.

Reset
REQ-036 While rst_n=0 at a clock edge, the block SHALL set: FSM=SYNC, wb=0, both full flags=0, wr_x=0, wr_y=0, rd_data=2'b00, wr_ready=0, underrun=0, resync=0, and the line-end edge detector=0.
REQ-037 Reset asserted mid-line SHALL abandon the partial line and both banks.
REQ-038 wr_ready SHALL become 1 in the first cycle after rst_n returns to 1.

Verification
REQ-039 Scenario: reset, then a wr_sof beat followed by 159 beats with data=x[1:0] -> bank 0 full, swap, and FSM in FILL one cycle later; then rd_y=0, rd_x=5 -> rd_data=2'b01 one cycle later.
REQ-040 Scenario: write lines 0 and 1, hold wr_valid=1 -> wr_ready=0 until line end of rd_y=0, then swap, and wr_ready=1 two cycles after line end.
REQ-041 Scenario: no writes, rd_y=0 sweeping rd_x 0..160 -> one underrun pulse at rd_x=0, and rd_data=0 throughout.
REQ-042 Scenario: wr_sof at wr_x=77 -> resync pulse, the line restarts at index 0, and only the new line's data is read.
REQ-043 Scenario: newframe while the FSM is in HOLD with both banks full -> both flags cleared, FSM=SYNC, and rd_data=0 for the next line.
REQ-044 Scenario: rst_n=0 held 1 cycle mid-FILL -> all outputs 0 next cycle, and wr_ready=1 the cycle after rst_n=1.
